// File: rtl/pcie_queue_ptr_mgr_pkg.sv
// rtl/pcie_queue_ptr_mgr_pkg.sv - shared register map, FSM states and per-queue register type
package pcie_queue_ptr_mgr_pkg;

   localparam int QREG_TAIL    = 0;
   localparam int QREG_HEAD    = 1;
   localparam int QREG_KMEM_LO = 2;
   localparam int QREG_KMEM_HI = 3;
   localparam int QREG_CTRL    = 4;

   localparam int CTRL_ENABLE  = 0;

   typedef struct packed {
      logic [31:0] tail;
      logic [31:0] head;
      logic [31:0] kmem_lo;
      logic [31:0] kmem_hi;
      logic [31:0] ctrl;
   } queue_regs_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL  = 2'd1,
      ST_REQ  = 2'd2,
      ST_WAIT = 2'd3
   } mgr_state_t;

endpackage

// File: rtl/pcie_queue_ptr_mgr_rr_arbiter.sv
// rtl/pcie_queue_ptr_mgr_rr_arbiter.sv - combinational round-robin arbiter, first request at or after base
module rr_arbiter #(
   parameter int N = 16,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] base,
   output logic [W-1:0] grant,
   output logic         any_grant
);

   logic [W-1:0] idx;

   // N is a power of two, so the W-bit add wraps the scan around the vector
   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      idx       = '0;
      for (int i = 0; i < N; i++) begin
         idx = base + W'(i);
         if (!any_grant && req[idx]) begin
            grant     = idx;
            any_grant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pcie_queue_ptr_mgr.sv
// rtl/pcie_queue_ptr_mgr.sv - per-queue ring pointer registers, PIO access and round-robin DMA snapshot issue
module pcie_queue_ptr_mgr
   import pcie_queue_ptr_mgr_pkg::*;
#(
   parameter int NB_QUEUES       = 16,
   parameter int QIDX_W          = $clog2(NB_QUEUES),
   parameter int RB_AWIDTH       = 16,
   parameter int PCIE_ADDR_WIDTH = 30,
   parameter int PAGE_SHIFT      = 12
) (
   input  logic                       pcie_clk,
   input  logic                       pcie_reset_n,
   input  logic [PCIE_ADDR_WIDTH-1:0] pio_address,
   input  logic                       pio_write,
   input  logic                       pio_read,
   input  logic [511:0]               pio_writedata,
   input  logic [63:0]                pio_byteenable,
   output logic [511:0]               pio_readdata,
   output logic                       pio_readdatavalid,
   input  logic [RB_AWIDTH-1:0]       rb_size,
   output logic                       dma_req_valid,
   input  logic                       dma_req_ready,
   output logic [QIDX_W-1:0]          dma_req_qid,
   output logic [RB_AWIDTH-1:0]       dma_req_head,
   output logic [RB_AWIDTH-1:0]       dma_req_tail,
   output logic [63:0]                dma_req_kmem_addr,
   input  logic                       dma_done,
   input  logic [RB_AWIDTH-1:0]       dma_new_tail
);

   queue_regs_t          regs [NB_QUEUES];
   mgr_state_t           state, state_nx;
   logic [QIDX_W-1:0]    rr_ptr;
   logic [QIDX_W-1:0]    pio_page;
   logic                 page_hit;
   logic [NB_QUEUES-1:0] q_enable;
   logic [QIDX_W-1:0]    arb_grant;
   logic                 arb_any;
   logic                 tail_commit;
   logic [RB_AWIDTH-1:0] commit_tail;
   logic [511:0]         rd_word;
   logic [511:0]         rd_s1;
   logic                 rd_v1;
   logic                 unused_inputs;

   assign pio_page    = pio_address[PAGE_SHIFT +: QIDX_W];
   assign page_hit    = (pio_address >> (PAGE_SHIFT + QIDX_W)) == '0;
   assign tail_commit = (state == ST_WAIT) && dma_done;
   assign commit_tail = dma_new_tail & (rb_size - 1'b1);

   assign unused_inputs = ^{pio_address[PAGE_SHIFT-1:0],
                            pio_writedata[32*QREG_TAIL +: 32],
                            pio_writedata[511:32*(QREG_CTRL+1)],
                            pio_byteenable[4*QREG_TAIL +: 4],
                            pio_byteenable[63:4*(QREG_CTRL+1)]};

   always_comb begin
      q_enable = '0;
      for (int i = 0; i < NB_QUEUES; i++) begin
         q_enable[i] = regs[i].ctrl[CTRL_ENABLE];
      end
   end

   rr_arbiter #(.N(NB_QUEUES), .W(QIDX_W)) u_arb (
      .req       (q_enable),
      .base      (rr_ptr),
      .grant     (arb_grant),
      .any_grant (arb_any)
   );

   // Only whole dwords are written; TAIL is owned by the DMA completion path
   always_ff @(posedge pcie_clk) begin
      if (!pcie_reset_n) begin
         for (int i = 0; i < NB_QUEUES; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (pio_write && page_hit) begin
            if (&pio_byteenable[4*QREG_HEAD +: 4])
               regs[pio_page].head <= pio_writedata[32*QREG_HEAD +: 32];
            if (&pio_byteenable[4*QREG_KMEM_LO +: 4])
               regs[pio_page].kmem_lo <= pio_writedata[32*QREG_KMEM_LO +: 32];
            if (&pio_byteenable[4*QREG_KMEM_HI +: 4])
               regs[pio_page].kmem_hi <= pio_writedata[32*QREG_KMEM_HI +: 32];
            if (&pio_byteenable[4*QREG_CTRL +: 4])
               regs[pio_page].ctrl <= pio_writedata[32*QREG_CTRL +: 32];
         end
         if (tail_commit)
            regs[dma_req_qid].tail <= 32'(commit_tail);
      end
   end

   always_comb begin
      rd_word = '0;
      if (page_hit) begin
         rd_word[32*QREG_TAIL    +: 32] = regs[pio_page].tail;
         rd_word[32*QREG_HEAD    +: 32] = regs[pio_page].head;
         rd_word[32*QREG_KMEM_LO +: 32] = regs[pio_page].kmem_lo;
         rd_word[32*QREG_KMEM_HI +: 32] = regs[pio_page].kmem_hi;
         rd_word[32*QREG_CTRL    +: 32] = regs[pio_page].ctrl;
      end
   end

   // Registers are sampled in the strobe cycle, so a same-cycle tail commit is not visible
   always_ff @(posedge pcie_clk) begin
      if (!pcie_reset_n) begin
         rd_v1             <= 1'b0;
         rd_s1             <= '0;
         pio_readdatavalid <= 1'b0;
         pio_readdata      <= '0;
      end else begin
         rd_v1             <= pio_read;
         rd_s1             <= rd_word;
         pio_readdatavalid <= rd_v1;
         pio_readdata      <= rd_s1;
      end
   end

   always_comb begin
      state_nx      = state;
      dma_req_valid = 1'b0;
      case (state)
         ST_IDLE: if (|q_enable) state_nx = ST_SEL;
         ST_SEL:  state_nx = arb_any ? ST_REQ : ST_IDLE;
         ST_REQ: begin
            dma_req_valid = 1'b1;
            if (dma_req_ready) state_nx = ST_WAIT;
         end
         ST_WAIT: if (dma_done) state_nx = ST_SEL;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge pcie_clk) begin
      if (!pcie_reset_n) begin
         state             <= ST_IDLE;
         rr_ptr            <= '0;
         dma_req_qid       <= '0;
         dma_req_head      <= '0;
         dma_req_tail      <= '0;
         dma_req_kmem_addr <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_SEL && arb_any) begin
            dma_req_qid       <= arb_grant;
            dma_req_head      <= regs[arb_grant].head[RB_AWIDTH-1:0];
            dma_req_tail      <= regs[arb_grant].tail[RB_AWIDTH-1:0];
            dma_req_kmem_addr <= {regs[arb_grant].kmem_hi, regs[arb_grant].kmem_lo};
         end
         if (state == ST_REQ && dma_req_ready)
            rr_ptr <= dma_req_qid + QIDX_W'(1);
      end
   end

endmodule

// File: tb/tb_pcie_queue_ptr_mgr.sv
// tb/tb_pcie_queue_ptr_mgr.sv - directed scoreboard bench for pcie_queue_ptr_mgr
module tb_pcie_queue_ptr_mgr;

   localparam int NBQ = 16;
   localparam int QW  = 4;
   localparam int RBW = 16;
   localparam int AW  = 30;

   logic            pcie_clk = 1'b0;
   logic            pcie_reset_n;
   logic [AW-1:0]   pio_address;
   logic            pio_write;
   logic            pio_read;
   logic [511:0]    pio_writedata;
   logic [63:0]     pio_byteenable;
   logic [511:0]    pio_readdata;
   logic            pio_readdatavalid;
   logic [RBW-1:0]  rb_size;
   logic            dma_req_valid;
   logic            dma_req_ready;
   logic [QW-1:0]   dma_req_qid;
   logic [RBW-1:0]  dma_req_head;
   logic [RBW-1:0]  dma_req_tail;
   logic [63:0]     dma_req_kmem_addr;
   logic            dma_done;
   logic [RBW-1:0]  dma_new_tail;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [511:0] rd_exp_q[$];
   int           rd_cyc_q[$];
   int           qid_q[$];
   logic [511:0] mon_e;
   int           mon_c;

   logic [31:0] tail_m[NBQ];
   logic [31:0] head_m[NBQ];
   logic [31:0] klo_m[NBQ];
   logic [31:0] khi_m[NBQ];
   logic [31:0] ctrl_m[NBQ];

   logic [RBW-1:0] s_head, s_tail;
   logic [63:0]    s_kmem;
   int             wait_n;

   always #5 pcie_clk = ~pcie_clk;
   always @(posedge pcie_clk) cyc <= cyc + 1;

   pcie_queue_ptr_mgr dut (
      .pcie_clk          (pcie_clk),
      .pcie_reset_n      (pcie_reset_n),
      .pio_address       (pio_address),
      .pio_write         (pio_write),
      .pio_read          (pio_read),
      .pio_writedata     (pio_writedata),
      .pio_byteenable    (pio_byteenable),
      .pio_readdata      (pio_readdata),
      .pio_readdatavalid (pio_readdatavalid),
      .rb_size           (rb_size),
      .dma_req_valid     (dma_req_valid),
      .dma_req_ready     (dma_req_ready),
      .dma_req_qid       (dma_req_qid),
      .dma_req_head      (dma_req_head),
      .dma_req_tail      (dma_req_tail),
      .dma_req_kmem_addr (dma_req_kmem_addr),
      .dma_done          (dma_done),
      .dma_new_tail      (dma_new_tail)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Read scoreboard: data and arrival cycle pushed when the strobe is driven
   always @(negedge pcie_clk) begin
      if (pio_readdatavalid === 1'b1) begin
         if (rd_exp_q.size() == 0) begin
            check("rd_unexpected", 512'(pio_readdatavalid), 512'(0));
         end else begin
            mon_e = rd_exp_q.pop_front();
            mon_c = rd_cyc_q.pop_front();
            check("rd_data", pio_readdata, mon_e);
            check("rd_latency", 512'(cyc), 512'(mon_c));
         end
      end
   end

   task automatic tick();
      @(posedge pcie_clk);
      #1;
   endtask

   function automatic logic [511:0] dw(input int k, input logic [31:0] v);
      logic [511:0] w;
      w = '0;
      w[32*k +: 32] = v;
      return w;
   endfunction

   function automatic logic [63:0] be4(input int k, input logic [3:0] v);
      logic [63:0] b;
      b = '0;
      b[4*k +: 4] = v;
      return b;
   endfunction

   function automatic logic [511:0] page_word(input int q);
      return dw(0, tail_m[q]) | dw(1, head_m[q]) | dw(2, klo_m[q]) | dw(3, khi_m[q]) | dw(4, ctrl_m[q]);
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NBQ; i++) begin
         tail_m[i] = '0; head_m[i] = '0; klo_m[i] = '0; khi_m[i] = '0; ctrl_m[i] = '0;
      end
   endtask

   task automatic pio_wr(input int page, input logic [511:0] data, input logic [63:0] be);
      pio_address    = AW'(page) << 12;
      pio_writedata  = data;
      pio_byteenable = be;
      pio_write      = 1'b1;
      tick();
      pio_write      = 1'b0;
      pio_writedata  = '0;
      pio_byteenable = '0;
   endtask

   task automatic pio_rd(input int page, input logic [511:0] exp);
      pio_address = AW'(page) << 12;
      pio_read    = 1'b1;
      rd_exp_q.push_back(exp);
      rd_cyc_q.push_back(cyc + 2);
      tick();
      pio_read = 1'b0;
   endtask

   task automatic check_snap(input string tag, input int q);
      check({tag, "_valid"}, 512'(dma_req_valid), 512'(1));
      check({tag, "_qid"},   512'(dma_req_qid), 512'(q));
      check({tag, "_head"},  512'(dma_req_head), 512'(head_m[q][RBW-1:0]));
      check({tag, "_tail"},  512'(dma_req_tail), 512'(tail_m[q][RBW-1:0]));
      check({tag, "_kmem"},  512'(dma_req_kmem_addr), 512'({khi_m[q], klo_m[q]}));
   endtask

   task automatic wait_valid();
      wait_n = 0;
      while (dma_req_valid !== 1'b1 && wait_n < 20) begin
         tick();
         wait_n++;
      end
   endtask

   task automatic do_req(input logic [RBW-1:0] nt);
      int q;
      dma_req_ready = 1'b1;
      wait_valid();
      q = qid_q.pop_front();
      check_snap("req", q);
      tick();
      dma_req_ready = 1'b0;
      tick();
      tick();
      dma_done     = 1'b1;
      dma_new_tail = nt;
      tick();
      dma_done     = 1'b0;
      tail_m[q]    = 32'(nt & (rb_size - 16'd1));
   endtask

   initial begin
      pcie_reset_n   = 1'b0;
      pio_address    = '0;
      pio_write      = 1'b0;
      pio_read       = 1'b0;
      pio_writedata  = '0;
      pio_byteenable = '0;
      rb_size        = 16'd1024;
      dma_req_ready  = 1'b0;
      dma_done       = 1'b0;
      dma_new_tail   = '0;
      clear_model();
      repeat (3) tick();

      check("rst_rdvalid", 512'(pio_readdatavalid), 512'(0));
      check("rst_reqvalid", 512'(dma_req_valid), 512'(0));
      check("rst_qid", 512'(dma_req_qid), 512'(0));
      check("rst_head", 512'(dma_req_head), 512'(0));
      check("rst_tail", 512'(dma_req_tail), 512'(0));
      check("rst_kmem", 512'(dma_req_kmem_addr), 512'(0));
      pcie_reset_n = 1'b1;
      tick();

      // Full-beat write; dword0 (TAIL) and dword6 (unmapped) must be ignored
      pio_wr(3, dw(0, 32'hAA) | dw(1, 32'h10) | dw(2, 32'h1000) | dw(3, 32'h2) | dw(4, 32'h1) | dw(6, 32'h66), '1);
      head_m[3] = 32'h10; klo_m[3] = 32'h1000; khi_m[3] = 32'h2; ctrl_m[3] = 32'h1;
      pio_rd(3, page_word(3));

      pio_wr(3, dw(0, 32'hFF) | dw(1, 32'hBEEF), be4(0, 4'hF) | be4(1, 4'h7));
      pio_rd(3, page_word(3));

      // Page 19 aliases page 3 only if upper address bits were ignored
      pio_wr(19, dw(1, 32'hDEAD), '1);
      pio_rd(19, '0);
      pio_rd(3, page_word(3));

      check_snap("snap_q3", 3);
      repeat (3) tick();

      pcie_reset_n = 1'b0;
      tick();
      pcie_reset_n = 1'b1;
      clear_model();
      tick();
      check("rst_req_drop", 512'(dma_req_valid), 512'(0));

      pio_wr(1, dw(4, 32'h1), be4(4, 4'hF));
      pio_wr(2, dw(4, 32'h1), be4(4, 4'hF));
      pio_wr(5, dw(4, 32'h1), be4(4, 4'hF));
      ctrl_m[1] = 32'h1; ctrl_m[2] = 32'h1; ctrl_m[5] = 32'h1;
      qid_q.push_back(1); qid_q.push_back(2); qid_q.push_back(5);
      qid_q.push_back(1); qid_q.push_back(2);
      do_req(16'd107);
      do_req(16'd208);
      do_req(16'd311);
      do_req(16'd412);
      do_req(16'd513);
      pio_rd(1, page_word(1));
      pio_rd(2, page_word(2));
      pio_rd(5, page_word(5));

      // q5 request held while the CPU rewrites its HEAD
      wait_valid();
      check_snap("hold_start", 5);
      s_head = dma_req_head;
      s_tail = dma_req_tail;
      s_kmem = dma_req_kmem_addr;
      s_head = head_m[5][RBW-1:0];
      s_tail = tail_m[5][RBW-1:0];
      s_kmem = {khi_m[5], klo_m[5]};
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin
            pio_address    = AW'(5) << 12;
            pio_writedata  = dw(1, 32'h33);
            pio_byteenable = be4(1, 4'hF);
            pio_write      = 1'b1;
            head_m[5]      = 32'h33;
         end else begin
            pio_write      = 1'b0;
         end
         check("hold_valid", 512'(dma_req_valid), 512'(1));
         check("hold_qid", 512'(dma_req_qid), 512'(5));
         check("hold_head", 512'(dma_req_head), 512'(s_head));
         check("hold_tail", 512'(dma_req_tail), 512'(s_tail));
         check("hold_kmem", 512'(dma_req_kmem_addr), 512'(s_kmem));
         tick();
      end
      pio_write = 1'b0;
      dma_req_ready = 1'b1;
      tick();
      dma_req_ready = 1'b0;
      check("wait_novalid", 512'(dma_req_valid), 512'(0));

      // Commit 1030 mod 1024 with a same-cycle read of the old TAIL
      dma_done     = 1'b1;
      dma_new_tail = 16'd1030;
      pio_rd(5, page_word(5));
      dma_done     = 1'b0;
      tail_m[5]    = 32'd6;
      pio_rd(5, page_word(5));

      qid_q.push_back(1); qid_q.push_back(2); qid_q.push_back(5);
      do_req(16'd600);
      do_req(16'd2000);
      do_req(16'd37);

      // Reset while waiting for completion; the late completion must be dropped
      dma_req_ready = 1'b1;
      wait_valid();
      check("t6_valid", 512'(dma_req_valid), 512'(1));
      tick();
      dma_req_ready = 1'b0;
      pcie_reset_n = 1'b0;
      tick();
      tick();
      pcie_reset_n = 1'b1;
      clear_model();
      tick();
      dma_done     = 1'b1;
      dma_new_tail = 16'd55;
      tick();
      dma_done     = 1'b0;
      repeat (3) tick();
      check("t6_reqvalid", 512'(dma_req_valid), 512'(0));
      check("t6_qid", 512'(dma_req_qid), 512'(0));
      check("t6_kmem", 512'(dma_req_kmem_addr), 512'(0));
      pio_rd(1, '0);
      pio_rd(2, '0);
      pio_rd(3, '0);
      pio_rd(5, '0);

      wait_n = 0;
      while (rd_exp_q.size() != 0 && wait_n < 10) begin
         tick();
         wait_n++;
      end
      check("rd_drain", 512'(rd_exp_q.size()), 512'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
